// File: rtl/peq_disp_pkg.sv
// Shared constants and state encoding for the gain-curve display path.
package peq_disp_pkg;

   localparam int DISP_COLS  = 1024;
   localparam int DISP_ADDRW = 10;
   localparam int LOG_MANTW  = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RENDER   = 2'd1,
      FLUSH    = 2'd2,
      WAITSWAP = 2'd3
   } gc_state_e;

endpackage

// File: rtl/gc_log2.sv
// Combinational log-scale height: priority encode, mantissa extract, shift, saturate.
module gc_log2
   import peq_disp_pkg::*;
#(
   parameter int AUDIOWIDTH = 16,
   parameter int DISPLWIDTH = 8,
   parameter int GAINSHIFT  = 1
) (
   input  logic [AUDIOWIDTH-1:0] mag,
   output logic [DISPLWIDTH-1:0] height
);

   localparam int PW   = (AUDIOWIDTH > 1) ? $clog2(AUDIOWIDTH) : 1;
   localparam int MAXH = (1 << DISPLWIDTH) - 1;

   logic [PW-1:0]        p;
   logic [LOG_MANTW-1:0] m;
   logic [31:0]          lin;
   logic [31:0]          scaled;

   always_comb begin
      p = '0;
      for (int i = 0; i < AUDIOWIDTH; i++) begin
         if (mag[i]) p = PW'(i);
      end
      // Bits below the leading one, left-aligned; missing low bits read as zero.
      m      = LOG_MANTW'({mag, {LOG_MANTW{1'b0}}} >> p);
      lin    = (32'(p) << LOG_MANTW) | 32'(m);
      scaled = lin << GAINSHIFT;
      if (scaled > 32'(MAXH)) height = DISPLWIDTH'(MAXH);
      else                    height = scaled[DISPLWIDTH-1:0];
   end

endmodule

// File: rtl/gcrender.sv
// Gain-curve renderer into a ping-pong display RAM, swapped on vsync fall.
// Optional GCRENDER_SMOOTH_EN: two-tap column smoothing with one extra pipeline stage.
module gcrender
   import peq_disp_pkg::*;
#(
   parameter int LOGFFTSIZE = 9,
   parameter int AUDIOWIDTH = 16,
   parameter int DISPLWIDTH = 8,
   parameter int GAINSHIFT  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vsync,
   input  logic                  update,
   output logic [LOGFFTSIZE-1:0] src_addr,
   input  logic [AUDIOWIDTH-1:0] src_data,
   input  logic [DISP_ADDRW-1:0] disp_addr,
   output logic [DISPLWIDTH-1:0] disp_data,
   output logic                  busy,
   output logic                  swapped
);

   localparam int ASHIFT = DISP_ADDRW - LOGFFTSIZE;
`ifdef GCRENDER_SMOOTH_EN
   localparam int FLUSH_LEN = 3;
`else
   localparam int FLUSH_LEN = 2;
`endif

   gc_state_e             state_reg, state_next;
   logic [DISP_ADDRW-1:0] col_reg, col_next;
   logic [1:0]            flush_reg, flush_next;
   logic                  pending_reg, pending_next;
   logic                  fsel_reg, fsel_next;
   logic                  swapped_reg, swapped_next;
   logic                  vs1_reg, vs2_reg;
   logic                  vfall;
   logic                  issue;

   assign vfall = vs2_reg & ~vs1_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         col_reg     <= '0;
         flush_reg   <= '0;
         pending_reg <= 1'b0;
         fsel_reg    <= 1'b0;
         swapped_reg <= 1'b0;
         vs1_reg     <= 1'b1;
         vs2_reg     <= 1'b1;
      end else begin
         state_reg   <= state_next;
         col_reg     <= col_next;
         flush_reg   <= flush_next;
         pending_reg <= pending_next;
         fsel_reg    <= fsel_next;
         swapped_reg <= swapped_next;
         vs1_reg     <= vsync;
         vs2_reg     <= vs1_reg;
      end
   end

   always_comb begin
      state_next   = state_reg;
      col_next     = col_reg;
      flush_next   = flush_reg;
      pending_next = pending_reg;
      fsel_next    = fsel_reg;
      swapped_next = 1'b0;
      issue        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (update) begin
               state_next = RENDER;
               col_next   = '0;
            end
         end
         RENDER: begin
            issue    = 1'b1;
            col_next = col_reg + 1'b1;
            if (update) pending_next = 1'b1;
            if (col_reg == DISP_ADDRW'(DISP_COLS - 1)) begin
               state_next = FLUSH;
               flush_next = '0;
            end
         end
         FLUSH: begin
            if (update) pending_next = 1'b1;
            flush_next = flush_reg + 1'b1;
            if (flush_reg == 2'(FLUSH_LEN - 1)) state_next = WAITSWAP;
         end
         WAITSWAP: begin
            if (vfall) begin
               // A coincident update is folded into pending: swap first, then re-render.
               fsel_next    = ~fsel_reg;
               swapped_next = 1'b1;
               if (pending_reg || update) begin
                  state_next   = RENDER;
                  col_next     = '0;
                  pending_next = 1'b0;
               end else begin
                  state_next = IDLE;
               end
            end else if (update) begin
               state_next   = RENDER;
               col_next     = '0;
               pending_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign src_addr = LOGFFTSIZE'(col_reg >> ASHIFT);
   assign busy     = (state_reg == RENDER) || (state_reg == FLUSH);
   assign swapped  = swapped_reg;

   // Pipeline: v1 = src_data valid this cycle, v2 = log height registered.
   logic                  v1_reg, v2_reg;
   logic [DISP_ADDRW-1:0] c1_reg, c2_reg;
   logic [DISPLWIDTH-1:0] h_comb, h2_reg;

   gc_log2 #(
      .AUDIOWIDTH(AUDIOWIDTH),
      .DISPLWIDTH(DISPLWIDTH),
      .GAINSHIFT (GAINSHIFT)
   ) u_log2 (
      .mag   (src_data),
      .height(h_comb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_reg <= 1'b0;
         v2_reg <= 1'b0;
         c1_reg <= '0;
         c2_reg <= '0;
         h2_reg <= '0;
      end else begin
         v1_reg <= issue;
         c1_reg <= col_reg;
         v2_reg <= v1_reg;
         c2_reg <= c1_reg;
         h2_reg <= h_comb;
      end
   end

   logic                  wr_en;
   logic [DISP_ADDRW-1:0] wr_col;
   logic [DISPLWIDTH-1:0] wr_data;

`ifdef GCRENDER_SMOOTH_EN
   logic                  v3_reg;
   logic [DISP_ADDRW-1:0] c3_reg;
   logic [DISPLWIDTH-1:0] s3_reg, hprev_reg;
   logic [DISPLWIDTH:0]   sum;

   // Column 0 has no left neighbour, so it averages with itself.
   assign sum = {1'b0, h2_reg} + {1'b0, (c2_reg == '0) ? h2_reg : hprev_reg};

   always_ff @(posedge clk) begin
      if (rst) begin
         v3_reg    <= 1'b0;
         c3_reg    <= '0;
         s3_reg    <= '0;
         hprev_reg <= '0;
      end else begin
         v3_reg <= v2_reg;
         c3_reg <= c2_reg;
         s3_reg <= sum[DISPLWIDTH:1];
         if (v2_reg) hprev_reg <= h2_reg;
      end
   end

   assign wr_en   = v3_reg;
   assign wr_col  = c3_reg;
   assign wr_data = s3_reg;
`else
   assign wr_en   = v2_reg;
   assign wr_col  = c2_reg;
   assign wr_data = h2_reg;
`endif

   // Both display buffers live in one array; the top address bit selects the half.
   logic [DISPLWIDTH-1:0] ram [0:2*DISP_COLS-1];

   always_ff @(posedge clk) begin
      if (wr_en) ram[{~fsel_reg, wr_col}] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) disp_data <= '0;
      else     disp_data <= ram[{fsel_reg, disp_addr}];
   end

endmodule

// File: tb/tb_gcrender.sv
// Randomized self-checking bench for gcrender (GAINSHIFT 1 and 2 instances side by side).
module tb_gcrender;

   localparam int LOGFFT = 9;
   localparam int AW     = 16;
   localparam int DW     = 8;

   logic              clk = 1'b0;
   logic              rst, vsync, update;
   logic [LOGFFT-1:0] src_addr1, src_addr2;
   logic [AW-1:0]     src_data1, src_data2;
   logic [9:0]        disp_addr;
   logic [DW-1:0]     disp_data1, disp_data2;
   logic              busy1, busy2, swapped1, swapped2;

   logic [AW-1:0]     gmem [0:(1<<LOGFFT)-1];
   int                errors = 0;
   int                checks = 0;
   int                swap_cnt = 0;

   always #5 clk = ~clk;

   gcrender #(.LOGFFTSIZE(LOGFFT), .AUDIOWIDTH(AW), .DISPLWIDTH(DW), .GAINSHIFT(1)) u_dut1 (
      .clk(clk), .rst(rst), .vsync(vsync), .update(update),
      .src_addr(src_addr1), .src_data(src_data1), .disp_addr(disp_addr),
      .disp_data(disp_data1), .busy(busy1), .swapped(swapped1));

   gcrender #(.LOGFFTSIZE(LOGFFT), .AUDIOWIDTH(AW), .DISPLWIDTH(DW), .GAINSHIFT(2)) u_dut2 (
      .clk(clk), .rst(rst), .vsync(vsync), .update(update),
      .src_addr(src_addr2), .src_data(src_data2), .disp_addr(disp_addr),
      .disp_data(disp_data2), .busy(busy2), .swapped(swapped2));

   // Gain memory with one-cycle read latency.
   always @(posedge clk) begin
      src_data1 <= gmem[src_addr1];
      src_data2 <= gmem[src_addr2];
   end

   always @(negedge clk) begin
      if (swapped1) swap_cnt <= swap_cnt + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Reference: height = (8*floor(log2 x) + next three bits) << gs, clipped at 255.
   function automatic int ref_h(input int x, input int gs);
      int p, m, h;
      if (x == 0) return 0;
      p = $clog2(x + 1) - 1;
      m = ((x * 8) >> p) % 8;
      h = (8 * p + m) << gs;
      return (h > 255) ? 255 : h;
   endfunction

   function automatic int exp_col(input int c, input int gs);
      int h;
      h = ref_h(int'(gmem[c / 2]), gs);
`ifdef GCRENDER_SMOOTH_EN
      begin
         int hp;
         hp = (c == 0) ? h : ref_h(int'(gmem[(c - 1) / 2]), gs);
         h = (h + hp) / 2;
      end
`endif
      return h;
   endfunction

   task automatic check_col_v(input string tag, input int c, input int e1, input int e2);
      @(negedge clk) disp_addr = 10'(c);
      @(negedge clk);
      check($sformatf("%s col%0d gs1", tag, c), int'(disp_data1), e1);
      check($sformatf("%s col%0d gs2", tag, c), int'(disp_data2), e2);
   endtask

   task automatic check_cols(input string tag, input int nrand);
      int fixed [4] = '{0, 6, 511, 1023};
      for (int i = 0; i < 4; i++) check_col_v(tag, fixed[i], exp_col(fixed[i], 1), exp_col(fixed[i], 2));
      for (int i = 0; i < nrand; i++) begin
         int c;
         c = $urandom_range(0, 1023);
         check_col_v(tag, c, exp_col(c, 1), exp_col(c, 2));
      end
   endtask

   task automatic do_update();
      @(negedge clk) update = 1'b1;
      @(negedge clk) update = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (busy1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (busy1) check({tag, " render timeout"}, 1, 0);
   endtask

   task automatic vsync_pulse();
      @(negedge clk) vsync = 1'b0;
      repeat (4) @(negedge clk);
      vsync = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic render_swap(input string tag);
      int s0;
      do_update();
      wait_done(tag);
      s0 = swap_cnt;
      vsync_pulse();
      check({tag, " swaps"}, swap_cnt - s0, 1);
   endtask

   initial begin
      int s0, old1, old2;
      rst = 1'b1; vsync = 1'b1; update = 1'b0; disp_addr = '0;
      for (int i = 0; i < (1 << LOGFFT); i++) gmem[i] = '0;
      repeat (3) @(negedge clk);
      check("rst busy", int'(busy1), 0);
      check("rst busy2", int'(busy2), 0);
      check("rst swapped", int'(swapped1), 0);
      check("rst src_addr", int'(src_addr1), 0);
      check("rst disp_data", int'(disp_data1), 0);
      rst = 1'b0;
      @(negedge clk);

      render_swap("zero");
      check_cols("zero", 0);

      for (int i = 0; i < (1 << LOGFFT); i++) gmem[i] = 16'h0100;
      render_swap("h0100");
      check_cols("h0100", 3);

      for (int i = 0; i < (1 << LOGFFT); i++) gmem[i] = 16'hFFFF;
      render_swap("hFFFF");
      check_cols("hFFFF", 3);

      for (int i = 0; i < (1 << LOGFFT); i++) gmem[i] = AW'(i);
      render_swap("ramp");
      check_col_v("ramp", 7, exp_col(7, 1), exp_col(7, 2));
      check_cols("ramp", 4);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < (1 << LOGFFT); i++) gmem[i] = AW'($urandom) >> $urandom_range(0, 15);
         render_swap("rand");
         check_cols("rand", 6);
      end

      // Long vsync-high hold: the front buffer must not change until vsync falls.
      old1 = exp_col(6, 1);
      old2 = exp_col(6, 2);
      for (int i = 0; i < (1 << LOGFFT); i++) gmem[i] = AW'(i * 37 + 1);
      do_update();
      wait_done("hold");
      s0 = swap_cnt;
      repeat (5000) @(negedge clk);
      check("hold swaps", swap_cnt - s0, 0);
      check_col_v("hold old", 6, old1, old2);
      vsync_pulse();
      check("hold swap after fall", swap_cnt - s0, 1);
      check_col_v("hold new", 6, exp_col(6, 1), exp_col(6, 2));

      // Several updates during one render collapse into a single re-render.
      for (int i = 0; i < (1 << LOGFFT); i++) gmem[i] = AW'($urandom) >> $urandom_range(0, 15);
      s0 = swap_cnt;
      do_update();
      repeat (20) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         do_update();
         repeat (50) @(negedge clk);
      end
      wait_done("multi1");
      vsync_pulse();
      check("multi first swap", swap_cnt - s0, 1);
      check("multi rerender busy", int'(busy1), 1);
      wait_done("multi2");
      vsync_pulse();
      check("multi second swap", swap_cnt - s0, 2);
      repeat (10) @(negedge clk);
      vsync_pulse();
      check("multi no third swap", swap_cnt - s0, 2);
      check_cols("multi", 3);

      // Reset mid-render, then a normal render.
      do_update();
      repeat (499) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst busy", int'(busy1), 0);
      check("midrst swapped", int'(swapped1), 0);
      check("midrst src_addr", int'(src_addr1), 0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < (1 << LOGFFT); i++) gmem[i] = AW'($urandom) >> $urandom_range(0, 15);
      render_swap("postrst");
      check_cols("postrst", 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
